// File: rtl/div_tc_32_16.sv
// Sequential signed divider: 32-bit dividend / 16-bit divisor, radix-2 on magnitudes with sign fix-up.
// Optional macro DIV_OVF_SAT_EN: saturate the quotient (and zero the remainder) on non-zero-divisor overflow.
module div_tc_32_16 #(
  parameter int DW_A = 32,
  parameter int DW_B = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW_A-1:0] dividend,
  input  logic [DW_B-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW_B-1:0] quotient,
  output logic [DW_B-1:0] remainder,
  output logic            overflow,
  output logic            div_zero,
  output logic            busy
);

  localparam int CW = $clog2(DW_A);
  localparam logic [DW_B-1:0] Q_MAX = {1'b0, {(DW_B-1){1'b1}}};
  localparam logic [DW_B-1:0] Q_MIN = {1'b1, {(DW_B-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW_A-1:0] dvd_q, dvd_d;
  logic [DW_A-1:0] quo_q, quo_d;
  logic [DW_B-1:0] dvs_q, dvs_d;
  logic [DW_B-1:0] dlo_q, dlo_d;
  logic [DW_B:0]   rem_q, rem_d;
  logic            sa_q, sa_d, sb_q, sb_d, zero_q, zero_d;
  logic [DW_B-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic            overflow_q, overflow_d, div_zero_q, div_zero_d;
  logic            out_valid_q, out_valid_d;

  // The partial remainder stays below |divisor| <= 2^(DW_B-1), so its low DW_B bits hold it exactly.
  logic [DW_B:0]   trial;
  logic [DW_B+1:0] diff;
  logic [DW_A:0]   q_ext, q_sgn;
  logic [DW_B-1:0] r_sgn;
  logic            q_ovf;

  always_comb begin
    trial = {rem_q[DW_B-1:0], dvd_q[DW_A-1]};
    diff  = {1'b0, trial} - {2'b00, dvs_q};
    q_ext = {1'b0, quo_q};
    q_sgn = (sa_q ^ sb_q) ? (~q_ext + (DW_A+1)'(1)) : q_ext;
    r_sgn = sa_q ? (~rem_q[DW_B-1:0] + DW_B'(1)) : rem_q[DW_B-1:0];
    // Representable in DW_B bits only if every bit from the DW_B-1 sign position up agrees.
    q_ovf = !((&q_sgn[DW_A:DW_B-1]) || !(|q_sgn[DW_A:DW_B-1]));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dlo_d       = dlo_q;
    rem_d       = rem_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    overflow_d  = overflow_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sa_d    = dividend[DW_A-1];
          sb_d    = divisor[DW_B-1];
          dvd_d   = dividend[DW_A-1] ? (~dividend + DW_A'(1)) : dividend;
          dvs_d   = divisor[DW_B-1] ? (~divisor + DW_B'(1)) : divisor;
          zero_d  = (divisor == '0);
          dlo_d   = dividend[DW_B-1:0];
          quo_d   = '0;
          rem_d   = '0;
          cnt_d   = CW'(DW_A-1);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = diff[DW_B+1] ? trial : diff[DW_B:0];
        quo_d = {quo_q[DW_A-2:0], ~diff[DW_B+1]};
        dvd_d = {dvd_q[DW_A-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        div_zero_d  = zero_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
        if (zero_q) begin
          overflow_d  = 1'b1;
          quotient_d  = sa_q ? Q_MIN : Q_MAX;
          remainder_d = dlo_q;
        end else begin
          overflow_d  = q_ovf;
          quotient_d  = q_sgn[DW_B-1:0];
          remainder_d = r_sgn;
`ifdef DIV_OVF_SAT_EN
          if (q_ovf) begin
            quotient_d  = q_sgn[DW_A] ? Q_MIN : Q_MAX;
            remainder_d = '0;
          end
`endif
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dlo_q       <= '0;
      rem_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dlo_q       <= dlo_d;
      rem_q       <= rem_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      overflow_q  <= overflow_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign overflow  = overflow_q;
  assign div_zero  = div_zero_q;

endmodule
